if_fetch_unit: RTL and testbench

- Producer side of the IF/ID pipeline register: owns the PC and issues instruction-memory reads over a req/ack handshake.
- Drives PC, instruction, exception flag/code and delay-slot tag into the IF/ID register.
- Obeys the same hold / clear-all / eret controls as that register, with identical priority, so both ends redirect in the same cycle.
- Reports fetch_stall to the hazard unit while a memory read is outstanding.

---
 rtl/cpu_defs_pkg.sv | 15 +
 rtl/if_addr_check.sv | 14 +
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: exception codes, reset/handler vectors and the IF fetch state encoding.
package cpu_defs_pkg;

    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LIMIT   = 32'h0000_6FFC;

    typedef logic [1:0] if_state_t;
    localparam if_state_t S_REQ   = 2'd0;
    localparam if_state_t S_HAVE  = 2'd1;
    localparam if_state_t S_DRAIN = 2'd2;

endpackage

// File: rtl/if_addr_check.sv
// Instruction-address legality check (alignment and window); also usable for MEM-stage accesses.
module if_addr_check
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
    input  logic [31:0] pc,
    output logic        adel
);

    assign adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage fetch unit: owns the PC, runs the imem req/ack handshake and feeds the IF/ID register.
// Address exception detection is enabled by defining IF_ADEL_CHECK_EN.
module if_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT   = DEF_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        clear_all,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_in_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] ins_if,
    output logic        exp_flag_if,
    output logic [4:0]  exc_code_if,
    output logic        delay_if,
    output logic        fetch_stall
);

`ifdef IF_ADEL_CHECK_EN
    localparam logic ADEL_EN = 1'b1;
`else
    localparam logic ADEL_EN = 1'b0;
`endif

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_buf_q, ins_buf_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    logic        adel_raw, adel;
    logic        in_req, in_have, in_drain;
    logic        valid, advance, redirect, busy;
    logic [31:0] addr_src;

    if_addr_check #(
        .IM_BASE  (IM_BASE),
        .IM_LIMIT (IM_LIMIT)
    ) u_addr_check (
        .pc   (pc_q),
        .adel (adel_raw)
    );

    assign adel = ADEL_EN & adel_raw;

    // Outputs are gated by reset so nothing is requested or presented while reset is asserted.
    always_comb begin
        in_req   = reset && (state_q == S_REQ);
        in_have  = reset && (state_q == S_HAVE);
        in_drain = reset && (state_q == S_DRAIN);
        valid    = in_have || (in_req && (imem_ack || adel));
        advance  = valid && !hold;
        redirect = eret || clear_all;
        busy     = (in_req && !adel && !imem_ack) || (in_drain && !imem_ack);
        addr_src = in_drain ? drain_addr_q : pc_q;
    end

    assign imem_req    = (in_req && !adel) || in_drain;
    assign imem_addr   = {addr_src[31:2], 2'b00};
    assign pc_if       = pc_q;
    assign ins_if      = !valid ? '0 : (in_have ? ins_buf_q : (adel ? '0 : imem_rdata));
    assign exp_flag_if = in_req && adel;
    assign exc_code_if = exp_flag_if ? EXC_ADEL : '0;
    assign delay_if    = valid && br_in_id;
    assign fetch_stall = !valid;

    always_comb begin
        state_d      = ((state_q == S_REQ) || (state_q == S_HAVE) || (state_q == S_DRAIN)) ? state_q : S_REQ;
        pc_d         = pc_q;
        ins_buf_d    = ins_buf_q;
        pend_v_d     = pend_v_q;
        pend_tgt_d   = pend_tgt_q;
        drain_addr_d = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

        if (redirect) begin
            pc_d       = eret ? epc : HANDLER_PC;
            pend_v_d   = 1'b0;
            pend_tgt_d = '0;
            state_d    = busy ? S_DRAIN : S_REQ;
        end else if (in_drain) begin
            if (imem_ack) begin
                state_d = S_REQ;
            end
        end else if (advance) begin
            pc_d     = br_taken ? br_target : (pend_v_q ? pend_tgt_q : pc_q + 32'd4);
            pend_v_d = 1'b0;
            state_d  = S_REQ;
        end else if (in_req && imem_ack && !adel) begin
            ins_buf_d = imem_rdata;
            state_d   = S_HAVE;
        end

        // A branch seen while its delay slot is still stalled is remembered until the slot advances.
        if (br_taken && !advance && !redirect) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = br_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            ins_buf_q    <= '0;
            pend_v_q     <= 1'b0;
            pend_tgt_q   <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ins_buf_q    <= ins_buf_d;
            pend_v_q     <= pend_v_d;
            pend_tgt_q   <= pend_tgt_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand sequences and a randomized model run.
module tb_if_fetch_unit;

`ifdef IF_ADEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] HND   = 32'h0000_4180;
    localparam logic [31:0] RST   = 32'h0000_3000;
    localparam logic [31:0] G     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0, clear_all = 1'b0, eret = 1'b0, br_taken = 1'b0, br_in_id = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] epc = '0, br_target = '0, imem_rdata = '0;
    logic        imem_req, exp_flag_if, delay_if, fetch_stall;
    logic [31:0] imem_addr, pc_if, ins_if;
    logic [4:0]  exc_code_if;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC   (RST),
        .HANDLER_PC (HND),
        .IM_BASE    (BASE),
        .IM_LIMIT   (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .clear_all   (clear_all),
        .eret        (eret),
        .epc         (epc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .br_in_id    (br_in_id),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_if       (pc_if),
        .ins_if      (ins_if),
        .exp_flag_if (exp_flag_if),
        .exc_code_if (exc_code_if),
        .delay_if    (delay_if),
        .fetch_stall (fetch_stall)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit          h, c, e;
        logic [31:0] ep;
        bit          b;
        logic [31:0] bt;
        bit          bid, ak;
        logic [31:0] rd;
        logic [31:0] xpc, xins;
        bit          xreq;
        logic [31:0] xaddr;
        bit          xst, xdl, xex;
    } vec_t;

    function automatic vec_t mk(bit h, bit c, bit e, logic [31:0] ep, bit b, logic [31:0] bt, bit bid, bit ak,
                                logic [31:0] rd, logic [31:0] xpc, logic [31:0] xins, bit xreq,
                                logic [31:0] xaddr, bit xst, bit xdl, bit xex);
        vec_t v;
        v.h = h; v.c = c; v.e = e; v.ep = ep; v.b = b; v.bt = bt; v.bid = bid; v.ak = ak; v.rd = rd;
        v.xpc = xpc; v.xins = xins; v.xreq = xreq; v.xaddr = xaddr; v.xst = xst; v.xdl = xdl; v.xex = xex;
        return v;
    endfunction

    // Reference model: PC, whether the word for PC is already held, a stale request being drained, pending branch.
    logic [31:0] m_pc, m_word, m_daddr, m_pt;
    bit          m_have, m_drain, m_pv;

    function automatic bit m_adel(input logic [31:0] a);
        return CHK && ((a[1:0] != 2'b00) || (a < BASE) || (a > LIMIT));
    endfunction

    function automatic bit m_req();
        return m_drain || (!m_have && !m_adel(m_pc));
    endfunction

    function automatic logic [31:0] m_addr();
        return (m_drain ? m_daddr : m_pc) & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic model_check();
        bit ad, valid;
        logic [31:0] ins;
        ad    = !m_drain && m_adel(m_pc);
        valid = !m_drain && (m_have || ad || imem_ack);
        ins   = !valid ? 32'h0 : (m_have ? m_word : (ad ? 32'h0 : imem_rdata));
        chk("rnd pc_if", pc_if, m_pc);
        chk("rnd ins_if", ins_if, ins);
        chk("rnd imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        chk("rnd imem_addr", imem_addr, m_addr());
        chk("rnd fetch_stall", {31'b0, fetch_stall}, {31'b0, !valid});
        chk("rnd delay_if", {31'b0, delay_if}, {31'b0, valid && br_in_id});
        chk("rnd exp_flag_if", {31'b0, exp_flag_if}, {31'b0, ad});
        chk("rnd exc_code_if", {27'b0, exc_code_if}, ad ? 32'd4 : 32'd0);
    endtask

    task automatic model_step();
        bit ad, valid, busy;
        ad    = !m_drain && m_adel(m_pc);
        valid = !m_drain && (m_have || ad || imem_ack);
        busy  = m_req() && !imem_ack;
        if (eret || clear_all) begin
            if (busy) begin
                if (!m_drain) m_daddr = m_pc;
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
            end
            m_pc = eret ? epc : HND;
            m_have = 1'b0;
            m_pv = 1'b0;
        end else if (m_drain) begin
            if (imem_ack) m_drain = 1'b0;
            if (br_taken) begin m_pv = 1'b1; m_pt = br_target; end
        end else if (valid && !hold) begin
            m_pc = br_taken ? br_target : (m_pv ? m_pt : m_pc + 32'd4);
            m_have = 1'b0;
            m_pv = 1'b0;
        end else begin
            if (!m_have && !ad && imem_ack) begin m_have = 1'b1; m_word = imem_rdata; end
            if (br_taken) begin m_pv = 1'b1; m_pt = br_target; end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1, 2: return BASE + 32'd4 * 32'($urandom_range(0, 32'hFFF));
            3:       return ($urandom_range(0, 1) == 1) ? 32'h0000_6FF8 : 32'h0000_6FFC;
            4:       return BASE + 32'd4 * 32'($urandom_range(0, 32'hFFF)) + 32'($urandom_range(1, 3));
            5:       return ($urandom_range(0, 1) == 1) ? 32'h0000_2FFC : 32'h0000_7000;
            default: return 32'h0000_3000 + 32'd4 * 32'($urandom_range(0, 15));
        endcase
    endfunction

    vec_t vecs[29];

    initial begin
        vecs[0]  = mk(0,0,0,0,0,0,0,1,32'hA000_0000, 32'h3000,32'hA000_0000,1,32'h3000,0,0,0);
        vecs[1]  = mk(0,0,0,0,0,0,0,1,32'hA000_0001, 32'h3004,32'hA000_0001,1,32'h3004,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0,1,32'hA000_0002, 32'h3008,32'hA000_0002,1,32'h3008,0,0,0);
        vecs[3]  = mk(0,0,0,0,0,0,0,0,G,             32'h300C,32'h0,       1,32'h300C,1,0,0);
        vecs[4]  = mk(0,0,0,0,0,0,0,0,G,             32'h300C,32'h0,       1,32'h300C,1,0,0);
        vecs[5]  = mk(0,0,0,0,0,0,0,0,G,             32'h300C,32'h0,       1,32'h300C,1,0,0);
        vecs[6]  = mk(1,0,0,0,0,0,0,1,32'hA000_0003, 32'h300C,32'hA000_0003,1,32'h300C,0,0,0);
        vecs[7]  = mk(1,0,0,0,0,0,0,0,G,             32'h300C,32'hA000_0003,0,32'h300C,0,0,0);
        vecs[8]  = mk(0,0,0,0,0,0,0,0,G,             32'h300C,32'hA000_0003,0,32'h300C,0,0,0);
        vecs[9]  = mk(0,0,0,0,1,32'h3100,1,1,32'hA000_0004, 32'h3010,32'hA000_0004,1,32'h3010,0,1,0);
        vecs[10] = mk(0,0,0,0,0,0,0,1,32'hA000_0005, 32'h3100,32'hA000_0005,1,32'h3100,0,0,0);
        vecs[11] = mk(0,0,0,0,1,32'h3200,1,0,G,      32'h3104,32'h0,       1,32'h3104,1,0,0);
        vecs[12] = mk(0,0,0,0,0,0,1,1,32'hA000_0006, 32'h3104,32'hA000_0006,1,32'h3104,0,1,0);
        vecs[13] = mk(0,0,0,0,0,0,0,1,32'hA000_0007, 32'h3200,32'hA000_0007,1,32'h3200,0,0,0);
        vecs[14] = mk(0,1,0,0,0,0,0,0,G,             32'h3204,32'h0,       1,32'h3204,1,0,0);
        vecs[15] = mk(0,0,0,0,0,0,0,0,G,             32'h4180,32'h0,       1,32'h3204,1,0,0);
        vecs[16] = mk(0,0,0,0,0,0,0,1,32'hA000_0008, 32'h4180,32'h0,       1,32'h3204,1,0,0);
        vecs[17] = mk(0,0,0,0,0,0,0,1,32'hA000_0009, 32'h4180,32'hA000_0009,1,32'h4180,0,0,0);
        vecs[18] = mk(0,0,1,32'h3002,0,0,0,1,32'hA000_000A, 32'h4184,32'hA000_000A,1,32'h4184,0,0,0);
        vecs[19] = mk(1,0,0,0,0,0,0,!CHK,32'hA000_000B, 32'h3002,CHK ? 32'h0 : 32'hA000_000B,!CHK,32'h3000,0,0,CHK);
        vecs[20] = mk(1,1,0,0,0,0,0,0,G,             32'h3002,CHK ? 32'h0 : 32'hA000_000B,0,32'h3000,0,0,CHK);
        vecs[21] = mk(0,0,0,0,0,0,0,1,32'hA000_000C, 32'h4180,32'hA000_000C,1,32'h4180,0,0,0);
        vecs[22] = mk(0,0,1,32'h6FFC,0,0,0,1,32'hA000_000D, 32'h4184,32'hA000_000D,1,32'h4184,0,0,0);
        vecs[23] = mk(0,0,0,0,0,0,0,1,32'hA000_000E, 32'h6FFC,32'hA000_000E,1,32'h6FFC,0,0,0);
        vecs[24] = mk(1,0,0,0,0,0,0,!CHK,32'hA000_000F, 32'h7000,CHK ? 32'h0 : 32'hA000_000F,!CHK,32'h7000,0,0,CHK);
        vecs[25] = mk(0,0,1,32'h2FFC,0,0,0,0,G,      32'h7000,CHK ? 32'h0 : 32'hA000_000F,0,32'h7000,0,0,CHK);
        vecs[26] = mk(1,0,0,0,0,0,0,!CHK,32'hA000_0010, 32'h2FFC,CHK ? 32'h0 : 32'hA000_0010,!CHK,32'h2FFC,0,0,CHK);
        vecs[27] = mk(0,1,0,0,0,0,0,0,G,             32'h2FFC,CHK ? 32'h0 : 32'hA000_0010,0,32'h2FFC,0,0,CHK);
        vecs[28] = mk(0,0,0,0,0,0,0,1,32'hA000_0011, 32'h4180,32'hA000_0011,1,32'h4180,0,0,0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pc_if", pc_if, RST);
        chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset ins_if", ins_if, 32'h0);
        chk("reset exp_flag_if", {31'b0, exp_flag_if}, 32'd0);
        chk("reset exc_code_if", {27'b0, exc_code_if}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 29; i++) begin
            hold = vecs[i].h; clear_all = vecs[i].c; eret = vecs[i].e; epc = vecs[i].ep;
            br_taken = vecs[i].b; br_target = vecs[i].bt; br_in_id = vecs[i].bid;
            imem_ack = vecs[i].ak; imem_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d pc_if", i), pc_if, vecs[i].xpc);
            chk($sformatf("vec%0d ins_if", i), ins_if, vecs[i].xins);
            chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].xreq});
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].xaddr);
            chk($sformatf("vec%0d fetch_stall", i), {31'b0, fetch_stall}, {31'b0, vecs[i].xst});
            chk($sformatf("vec%0d delay_if", i), {31'b0, delay_if}, {31'b0, vecs[i].xdl});
            chk($sformatf("vec%0d exp_flag_if", i), {31'b0, exp_flag_if}, {31'b0, vecs[i].xex});
            chk($sformatf("vec%0d exc_code_if", i), {27'b0, exc_code_if}, vecs[i].xex ? 32'd4 : 32'd0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of an outstanding, held request
        hold = 1'b1; clear_all = 1'b0; eret = 1'b0; br_taken = 1'b0; br_in_id = 1'b0;
        imem_ack = 1'b0; imem_rdata = G;
        @(negedge clk);
        chk("prearst imem_addr", imem_addr, 32'h4184);
        chk("prearst fetch_stall", {31'b0, fetch_stall}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst pc_if", pc_if, RST);
        chk("arst imem_req", {31'b0, imem_req}, 32'd0);
        chk("arst ins_if", ins_if, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1; hold = 1'b0;
        @(negedge clk);
        chk("postarst imem_req", {31'b0, imem_req}, 32'd1);
        chk("postarst imem_addr", imem_addr, RST);
        chk("postarst fetch_stall", {31'b0, fetch_stall}, 32'd1);
        @(posedge clk);
        #1 imem_ack = 1'b1; imem_rdata = 32'hB0B0_0001;
        @(negedge clk);
        chk("postarst ins_if", ins_if, 32'hB0B0_0001);
        chk("postarst pc_if", pc_if, RST);
        @(posedge clk);
        #1;

        // Randomized run against the reference model
        imem_ack = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        m_pc = RST; m_have = 1'b0; m_drain = 1'b0; m_pv = 1'b0;
        m_word = '0; m_daddr = '0; m_pt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            hold      = ($urandom_range(0, 3) == 0);
            clear_all = ($urandom_range(0, 24) == 0);
            eret      = ($urandom_range(0, 24) == 0);
            epc       = rand_addr();
            br_taken  = ($urandom_range(0, 5) == 0);
            br_target = rand_addr();
            br_in_id  = ($urandom_range(0, 1) == 1);
            imem_ack  = m_req() && ($urandom_range(0, 2) != 0);
            imem_rdata = imem_ack ? memw(m_addr()) : $urandom;
            @(negedge clk);
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
